// File: rtl/bus_sched.sv
// bus_sched: transaction-level owner of the shared 8-bit data bus.
// One engine (AES or SHA) is granted the bus for a whole transaction. Its bytes
// are streamed under the bus_ready handshake, and the grant is held until the
// addressed target raises its bit of ack_in. Contending engines alternate
// round-robin.
// Optional acknowledge watchdog: define BUS_SCHED_TIMEOUT_EN to abort a
// transaction whose acknowledge has not arrived after TIMEOUT cycles.

module bus_sched #(
   parameter int LENW    = 5,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            aes_req,
   input  logic [LENW-1:0] aes_len,
   input  logic [1:0]      aes_dest,
   input  logic [7:0]      aes_data,
   input  logic            sha_req,
   input  logic [LENW-1:0] sha_len,
   input  logic [1:0]      sha_dest,
   input  logic [7:0]      sha_data,
   input  logic [2:0]      ack_in,
   input  logic            bus_ready,
   output logic            aes_grant,
   output logic            sha_grant,
   output logic            aes_pop,
   output logic            sha_pop,
   output logic            aes_done,
   output logic            sha_done,
   output logic [7:0]      data_bus_out,
   output logic            data_bus_valid,
   output logic            timeout,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, WAIT_ACK = 2'd2} state_t;

   // Engine encoding used for owner and last winner: 0 = AES, 1 = SHA.
   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic            last_q, last_d;
   logic [LENW-1:0] cnt_q, cnt_d;
   logic [1:0]      dest_q, dest_d;
   logic            aes_grant_q, aes_grant_d, sha_grant_q, sha_grant_d;
   logic            aes_done_q, aes_done_d, sha_done_q, sha_done_d;
   logic            timeout_q, timeout_d;
   logic            ack_hit;
   logic            abort;
   logic            win;
   logic [LENW-1:0] win_len;

   // Only the addressed target's ack completes; dest 3 selects no target at all.
   always_comb begin
      ack_hit = 1'b0;
      case (dest_q)
         2'd0:    ack_hit = ack_in[0];
         2'd1:    ack_hit = ack_in[1];
         2'd2:    ack_hit = ack_in[2];
         default: ack_hit = 1'b0;
      endcase
   end

`ifdef BUS_SCHED_TIMEOUT_EN
   localparam int WAITW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [WAITW-1:0] wait_q, wait_d;

   // Wait counter: zero outside WAIT_ACK, so it starts from 0 on every entry.
   always_comb begin
      wait_d = '0;
      if (state_q == WAIT_ACK) begin
         wait_d = wait_q + WAITW'(1);
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   // Abort on the cycle the count reaches TIMEOUT; a same-cycle ack takes priority.
   assign abort = (state_q == WAIT_ACK) && !ack_hit && (wait_q == WAITW'(TIMEOUT - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT != 0);
   assign abort              = 1'b0;
`endif

   // Next-state and bus-side outputs: arbitration in IDLE, byte streaming in XFER.
   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      last_d         = last_q;
      cnt_d          = cnt_q;
      dest_d         = dest_q;
      aes_grant_d    = aes_grant_q;
      sha_grant_d    = sha_grant_q;
      aes_done_d     = 1'b0;
      sha_done_d     = 1'b0;
      timeout_d      = 1'b0;
      aes_pop        = 1'b0;
      sha_pop        = 1'b0;
      data_bus_out   = '0;
      data_bus_valid = 1'b0;
      win            = 1'b0;
      win_len        = '0;
      case (state_q)
         IDLE: begin
            aes_grant_d = 1'b0;
            sha_grant_d = 1'b0;
            if (aes_req || sha_req) begin
               // On a tie the engine not served last wins.
               win         = (aes_req && sha_req) ? ~last_q : sha_req;
               win_len     = win ? sha_len : aes_len;
               last_d      = win;
               aes_grant_d = ~win;
               sha_grant_d = win;
               if (win_len == '0) begin
                  // Empty transaction: grant and done pulse together, no bus activity.
                  aes_done_d = ~win;
                  sha_done_d = win;
               end else begin
                  owner_d = win;
                  cnt_d   = win_len;
                  dest_d  = win ? sha_dest : aes_dest;
                  state_d = XFER;
               end
            end
         end
         XFER: begin
            data_bus_valid = 1'b1;
            data_bus_out   = owner_q ? sha_data : aes_data;
            if (bus_ready) begin
               aes_pop = ~owner_q;
               sha_pop = owner_q;
               cnt_d   = cnt_q - LENW'(1);
               if (cnt_q == LENW'(1)) begin
                  state_d = WAIT_ACK;
               end
            end
         end
         WAIT_ACK: begin
            if (ack_hit) begin
               aes_done_d  = ~owner_q;
               sha_done_d  = owner_q;
               aes_grant_d = 1'b0;
               sha_grant_d = 1'b0;
               state_d     = IDLE;
            end else if (abort) begin
               timeout_d   = 1'b1;
               aes_grant_d = 1'b0;
               sha_grant_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered-output flops; last winner resets to SHA so AES wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         dest_q      <= '0;
         aes_grant_q <= 1'b0;
         sha_grant_q <= 1'b0;
         aes_done_q  <= 1'b0;
         sha_done_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         dest_q      <= dest_d;
         aes_grant_q <= aes_grant_d;
         sha_grant_q <= sha_grant_d;
         aes_done_q  <= aes_done_d;
         sha_done_q  <= sha_done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign aes_grant = aes_grant_q;
   assign sha_grant = sha_grant_q;
   assign aes_done  = aes_done_q;
   assign sha_done  = sha_done_q;
   assign timeout   = timeout_q;
   assign busy      = (state_q != IDLE);

endmodule
